// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage F/D/E/M/W core: E-stage forwarding,
// load-use stalls, PC-write stall/flush sequencing and a stall-cycle counter.
module hazard_control_unit #(
    parameter int RA_W     = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  ra1D,
    input  logic [RA_W-1:0]  ra2D,
    input  logic [RA_W-1:0]  ra1E,
    input  logic [RA_W-1:0]  ra2E,
    input  logic [RA_W-1:0]  wa3E,
    input  logic [RA_W-1:0]  wa3M,
    input  logic [RA_W-1:0]  wa3W,
    input  logic             regWriteE,
    input  logic             regWriteM,
    input  logic             regWriteW,
    input  logic             memtoRegE,
    input  logic             pcSrcD,
    input  logic             pcSrcW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [CNT_W-1:0] stallCycles
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] PCWAIT = 1'b1;

    // Reload value so that the hit cycle plus the countdown spans LOAD_LAT cycles.
    localparam logic [1:0] LD_INIT = 2'(LOAD_LAT - 1);

    logic [0:0]       state;
    logic [1:0]       ld_cnt;
    logic [CNT_W-1:0] cnt;

    logic ld_hit;
    logic ld_stall;
    logic pc_enter;

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] ra);
        if (regWriteM && wa3M == ra)
            return 2'b10;
        else if (regWriteW && wa3W == ra)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Hazard detection; a PC writer only advances once any load stall has cleared.
    always_comb begin
        ld_hit   = memtoRegE && regWriteE &&
                   (wa3E == ra1D || wa3E == ra2D) &&
                   state == IDLE && ld_cnt == 2'd0;
        ld_stall = ld_hit || ld_cnt != 2'd0;
        pc_enter = state == IDLE && pcSrcD && !ld_stall;
    end

    // Control outputs, forced low while reset is held.
    always_comb begin
        forwardAE   = 2'b00;
        forwardBE   = 2'b00;
        stallF      = 1'b0;
        stallD      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        stallCycles = '0;
        if (!reset) begin
            forwardAE   = fwd_sel(ra1E);
            forwardBE   = fwd_sel(ra2E);
            stallF      = ld_stall || pc_enter || state == PCWAIT;
            stallD      = ld_stall;
            flushD      = pc_enter || state == PCWAIT;
            flushE      = ld_stall;
            stallCycles = cnt;
        end
    end

    // PC-write FSM: wait with fetch frozen until the writer retires in W.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (pc_enter) state <= PCWAIT;
                PCWAIT:  if (pcSrcW)   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Load-use countdown covering the remaining stall cycles after a hit.
    always_ff @(posedge clk) begin
        if (reset)
            ld_cnt <= 2'd0;
        else if (ld_hit)
            ld_cnt <= LD_INIT;
        else if (ld_cnt != 2'd0)
            ld_cnt <= ld_cnt - 2'd1;
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (stallF && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

endmodule
